// File: rtl/dm_lsu.sv
// Load/store unit between the single-cycle datapath and a req/ack data memory.
// Aligns, byte-enables and replicates stores; extracts and extends loads; stalls the datapath meanwhile.
module dm_lsu #(
    parameter int ACK_FREE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  DMWr,
    input  logic [2:0]  DMRe,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        addr_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] DMWR_NOP = 2'd0;
    localparam logic [1:0] DMWR_SB  = 2'd1;
    localparam logic [1:0] DMWR_SH  = 2'd2;
    localparam logic [1:0] DMWR_SW  = 2'd3;

    localparam logic [2:0] DMRE_NOP = 3'd0;
    localparam logic [2:0] DMRE_LB  = 3'd1;
    localparam logic [2:0] DMRE_LBU = 3'd2;
    localparam logic [2:0] DMRE_LH  = 3'd3;
    localparam logic [2:0] DMRE_LHU = 3'd4;
    localparam logic [2:0] DMRE_LW  = 3'd5;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_r;
    logic [2:0]  ld_op_r;
    logic [1:0]  off_r;

    logic        store_s;
    logic        load_s;
    logic        pend_s;
    logic [1:0]  size_s;
    logic        mis_s;
    logic [3:0]  be_s;
    logic [31:0] wd_s;

    // ACK_FREE is reserved; nothing is built when it is nonzero.
    if (ACK_FREE != 0) begin : g_ack_free_reserved
    end

    // Select the byte/halfword lane of a read word and extend it to 32 bits.
    function automatic logic [31:0] extract_load(input logic [2:0]  op,
                                                 input logic [1:0]  off,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'd0;
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (op)
            DMRE_LB:  res = {{24{b[7]}}, b};
            DMRE_LBU: res = {24'd0, b};
            DMRE_LH:  res = {{16{h[15]}}, h};
            DMRE_LHU: res = {16'd0, h};
            DMRE_LW:  res = word;
            default:  res = 32'd0;
        endcase
        return res;
    endfunction

    // Decode the requested access: direction, size, alignment, lanes and store data.
    always_comb begin
        store_s = (DMWr != DMWR_NOP);
        case (DMRe)
            DMRE_LB, DMRE_LBU, DMRE_LH, DMRE_LHU, DMRE_LW: load_s = 1'b1;
            default:                                       load_s = 1'b0;
        endcase
        pend_s = store_s | load_s;

        // A store takes priority over a simultaneous load.
        if (store_s) begin
            case (DMWr)
                DMWR_SB: size_s = SZ_BYTE;
                DMWR_SH: size_s = SZ_HALF;
                DMWR_SW: size_s = SZ_WORD;
                default: size_s = SZ_BYTE;
            endcase
        end else begin
            case (DMRe)
                DMRE_LB, DMRE_LBU: size_s = SZ_BYTE;
                DMRE_LH, DMRE_LHU: size_s = SZ_HALF;
                DMRE_LW:           size_s = SZ_WORD;
                default:           size_s = SZ_BYTE;
            endcase
        end

        case (size_s)
            SZ_HALF: mis_s = addr[0];
            SZ_WORD: mis_s = (addr[1:0] != 2'd0);
            default: mis_s = 1'b0;
        endcase

        case (size_s)
            SZ_BYTE: be_s = 4'b0001 << addr[1:0];
            SZ_HALF: be_s = addr[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be_s = 4'b1111;
            default: be_s = 4'b0000;
        endcase

        case (size_s)
            SZ_BYTE: wd_s = {4{wdata[7:0]}};
            SZ_HALF: wd_s = {2{wdata[15:0]}};
            default: wd_s = wdata;
        endcase
    end

    // Stall must be combinational so the datapath freezes in the same cycle the access appears.
    always_comb begin
        if (state_r == ST_REQ) begin
            stall = 1'b1;
        end else if ((state_r == ST_IDLE) && pend_s && !rst) begin
            stall = 1'b1;
        end else begin
            stall = 1'b0;
        end
    end

    // Access FSM with registered memory-port and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            ld_op_r   <= DMRE_NOP;
            off_r     <= 2'd0;
            rdata     <= 32'd0;
            addr_err  <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 30'd0;
            mem_be    <= 4'd0;
            mem_wdata <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pend_s) begin
                        rdata <= 32'd0;
                        if (mis_s) begin
                            addr_err <= 1'b1;
                            state_r  <= ST_DONE;
                        end else begin
                            ld_op_r   <= store_s ? DMRE_NOP : DMRe;
                            off_r     <= addr[1:0];
                            mem_req   <= 1'b1;
                            mem_we    <= store_s;
                            mem_addr  <= addr[31:2];
                            mem_be    <= be_s;
                            mem_wdata <= wd_s;
                            state_r   <= ST_REQ;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (ld_op_r != DMRE_NOP) begin
                            rdata <= extract_load(ld_op_r, off_r, mem_rdata);
                        end else begin
                            rdata <= 32'd0;
                        end
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_REQ;
                    end
                end
                ST_DONE: begin
                    addr_err <= 1'b0;
                    state_r  <= ST_IDLE;
                end
                default: begin
                    mem_req  <= 1'b0;
                    addr_err <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_lsu.sv
// Randomized self-checking bench for dm_lsu against a byte-arithmetic reference model.
// The bench plays the memory side and drives ack latency per access.
module tb_dm_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  DMWr;
    logic [2:0]  DMRe;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        addr_err;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks = 0;
    int failures = 0;

    dm_lsu #(.ACK_FREE(0)) dut (
        .clk(clk), .rst(rst), .DMWr(DMWr), .DMRe(DMRe), .addr(addr), .wdata(wdata),
        .rdata(rdata), .stall(stall), .addr_err(addr_err), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One access from the datapath's view; delay is the REQ cycle (1-based) in which ack arrives.
    task automatic do_access(input logic [1:0] wr, input logic [2:0] re, input logic [31:0] a,
                             input logic [31:0] wd, input int delay, input logic [31:0] word,
                             input logic ack_hold);
        bit          is_st;
        bit          is_ld;
        bit          mis;
        bit          sgn;
        int          size;
        int          stalls;
        logic [31:0] mask;
        logic [31:0] exp_rd;
        logic [31:0] exp_wd;
        logic [3:0]  exp_be;

        is_st = (wr != 2'd0);
        is_ld = !is_st && (re >= 3'd1) && (re <= 3'd5);
        if (is_st) size = (wr == 2'd1) ? 1 : (wr == 2'd2) ? 2 : 4;
        else       size = (re == 3'd1 || re == 3'd2) ? 1 : (re == 3'd3 || re == 3'd4) ? 2 : 4;
        sgn = (re == 3'd1) || (re == 3'd3) || (re == 3'd5);
        mis = (int'(a[1:0]) % size) != 0;
        exp_be = 4'(((32'd1 << size) - 32'd1) << a[1:0]);
        if (size == 1)      exp_wd = {24'd0, wd[7:0]} * 32'h0101_0101;
        else if (size == 2) exp_wd = {16'd0, wd[15:0]} * 32'h0001_0001;
        else                exp_wd = wd;
        exp_rd = word >> (8 * int'(a[1:0]));
        if (size < 4) begin
            mask = (32'd1 << (8 * size)) - 32'd1;
            exp_rd = exp_rd & mask;
            if (sgn && exp_rd[8 * size - 1]) exp_rd = exp_rd | ~mask;
        end
        if (!is_ld) exp_rd = 32'd0;

        next_cycle();
        DMWr = wr; DMRe = re; addr = a; wdata = wd;
        mem_ack = ack_hold; mem_rdata = $urandom;
        #1;
        if (!is_st && !is_ld) begin
            check_val("nop_stall", {31'd0, stall}, 32'd0);
            check_val("nop_req", {31'd0, mem_req}, 32'd0);
            return;
        end
        stalls = stall ? 1 : 0;
        check_val("c0_req", {31'd0, mem_req}, 32'd0);

        if (mis) begin
            next_cycle();
            mem_ack = ack_hold;
            #1;
            stalls += stall ? 1 : 0;
            check_val("mis_err", {31'd0, addr_err}, 32'd1);
            check_val("mis_req", {31'd0, mem_req}, 32'd0);
            check_val("mis_rdata", rdata, 32'd0);
            check_val("mis_stalls", stalls, 32'd1);
            next_cycle();
            DMWr = 2'd0; DMRe = 3'd0;
            #1;
            check_val("mis_err_pulse", {31'd0, addr_err}, 32'd0);
            check_val("mis_idle_req", {31'd0, mem_req}, 32'd0);
            return;
        end

        for (int k = 1; k <= delay; k++) begin
            next_cycle();
            mem_ack = ack_hold || (k == delay);
            mem_rdata = (k == delay) ? word : $urandom;
            #1;
            stalls += stall ? 1 : 0;
            check_val("req_req", {31'd0, mem_req}, 32'd1);
            check_val("req_addr", {2'd0, mem_addr}, {2'd0, a[31:2]});
            check_val("req_we", {31'd0, mem_we}, {31'd0, is_st});
            if (is_st) begin
                check_val("req_be", {28'd0, mem_be}, {28'd0, exp_be});
                check_val("req_wdata", mem_wdata, exp_wd);
            end
        end
        next_cycle();
        mem_ack = ack_hold; mem_rdata = $urandom;
        #1;
        check_val("done_stall", {31'd0, stall}, 32'd0);
        check_val("done_req", {31'd0, mem_req}, 32'd0);
        check_val("done_err", {31'd0, addr_err}, 32'd0);
        check_val("done_rdata", rdata, exp_rd);
        check_val("stall_cycles", stalls, 32'(1 + delay));
    endtask

    initial begin
        rst = 1'b1; DMWr = 2'd0; DMRe = 3'd0; addr = 32'd0; wdata = 32'd0;
        mem_ack = 1'b0; mem_rdata = 32'd0;
        repeat (3) next_cycle();
        rst = 1'b0;
        #1;
        check_val("rst_rdata", rdata, 32'd0);
        check_val("rst_stall", {31'd0, stall}, 32'd0);
        check_val("rst_req", {31'd0, mem_req}, 32'd0);
        check_val("rst_err", {31'd0, addr_err}, 32'd0);
        check_val("rst_be", {28'd0, mem_be}, 32'd0);

        do_access(2'd3, 3'd0, 32'h10, 32'hDEAD_BEEF, 1, 32'd0, 1'b1);
        do_access(2'd0, 3'd1, 32'h13, 32'd0, 1, 32'h80FF_7F01, 1'b0);
        do_access(2'd0, 3'd2, 32'h13, 32'd0, 2, 32'h80FF_7F01, 1'b0);
        do_access(2'd0, 3'd3, 32'h12, 32'd0, 1, 32'h80FF_7F01, 1'b0);
        do_access(2'd0, 3'd4, 32'h10, 32'd0, 3, 32'h80FF_7F01, 1'b0);
        do_access(2'd2, 3'd0, 32'h22, 32'h1234_ABCD, 1, 32'd0, 1'b0);
        do_access(2'd1, 3'd0, 32'h21, 32'h0000_00A5, 2, 32'd0, 1'b0);
        do_access(2'd0, 3'd5, 32'h06, 32'd0, 1, 32'd0, 1'b0);
        do_access(2'd0, 3'd5, 32'h40, 32'd0, 5, $urandom, 1'b0);
        do_access(2'd1, 3'd1, 32'h33, 32'h0000_005A, 1, 32'hFFFF_FFFF, 1'b0);

        // Reset in the second REQ cycle, then a stray ack.
        next_cycle();
        DMWr = 2'd0; DMRe = 3'd5; addr = 32'h40; mem_ack = 1'b0;
        #1;
        check_val("ra_stall0", {31'd0, stall}, 32'd1);
        next_cycle();
        #1;
        check_val("ra_req1", {31'd0, mem_req}, 32'd1);
        next_cycle();
        rst = 1'b1;
        #1;
        check_val("ra_req2", {31'd0, mem_req}, 32'd1);
        next_cycle();
        rst = 1'b0; DMRe = 3'd0; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        #1;
        check_val("ra_req_drop", {31'd0, mem_req}, 32'd0);
        check_val("ra_stall", {31'd0, stall}, 32'd0);
        check_val("ra_rdata", rdata, 32'd0);
        next_cycle();
        mem_ack = 1'b0;
        #1;
        check_val("ra_stray_req", {31'd0, mem_req}, 32'd0);
        check_val("ra_stray_stall", {31'd0, stall}, 32'd0);
        check_val("ra_stray_rdata", rdata, 32'd0);
        check_val("ra_stray_err", {31'd0, addr_err}, 32'd0);
        do_access(2'd0, 3'd4, 32'h46, 32'd0, 1, 32'hC3A5_1234, 1'b0);

        for (int n = 0; n < 80; n++) begin
            logic [1:0]  r_wr;
            logic [2:0]  r_re;
            r_wr = 2'($urandom_range(0, 3));
            r_re = 3'($urandom_range(0, 5));
            do_access(r_wr, r_re, $urandom, $urandom, $urandom_range(1, 4), $urandom, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
